// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared opcode constants and fetch state type
package processor_pkg;

  // Opcode field position inside an 18-bit instruction word
  localparam int OPCODE_WIDTH = 4;

  localparam logic [OPCODE_WIDTH-1:0] OP_CALL_IMM14 = 4'hC;
  localparam logic [OPCODE_WIDTH-1:0] OP_IF         = 4'hD;
  localparam logic [OPCODE_WIDTH-1:0] OP_RETURN     = 4'hE;
  localparam logic [OPCODE_WIDTH-1:0] OP_WAIT       = 4'hF;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    RUN      = 2'd1,
    RET_WAIT = 2'd2,
    HALT     = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/processor_stage1.sv
// rtl/processor_stage1.sv - instruction fetch stage driving synchronous code memory
module processor_stage1
  import processor_pkg::*;
#(
  parameter int                   ADDR_SIZE    = 18,
  parameter int                   WORD_SIZE    = 18,
  parameter logic [ADDR_SIZE-1:0] RESET_VECTOR = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [ADDR_SIZE-1:0] code_addr,
  output logic                 code_read_enable,
  input  logic [WORD_SIZE-1:0] code_data,
  output logic                 no_operation,
  output logic [ADDR_SIZE-1:0] ip,
  output logic [ADDR_SIZE-1:0] ip_plus_one,
  output logic [WORD_SIZE-1:0] code_word,
  input  logic                 call_performed,
  input  logic [ADDR_SIZE-1:0] ip_to_call,
  input  logic                 return_performed,
  input  logic [WORD_SIZE-1:0] return_addr,
  input  logic                 waiting_global
);

  localparam logic [ADDR_SIZE-1:0] ADDR_ONE = 1;

  fetch_state_t           state_q, state_d;
  logic [ADDR_SIZE-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_SIZE-1:0]   ip_q, ip_d;
  logic                   no_op_q, no_op_d;
  logic                   read_en_q, read_en_d;
  logic [OPCODE_WIDTH-1:0] opcode;

  // The only predecode this stage needs: spotting a return on the delivered word
  assign opcode = code_data[WORD_SIZE-1 -: OPCODE_WIDTH];

  assign code_addr        = fetch_pc_q;
  assign code_word        = code_data;
  assign ip               = ip_q;
  assign ip_plus_one      = ip_q + ADDR_ONE;
  assign no_operation     = no_op_q;
  assign code_read_enable = read_en_q;

  // Next-state / next-pc selection; halt outranks every redirect
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    ip_d       = ip_q;
    no_op_d    = no_op_q;
    if (waiting_global) begin
      state_d = HALT;
      no_op_d = 1'b1;
    end else begin
      case (state_q)
        FILL: begin
          ip_d       = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + ADDR_ONE;
          no_op_d    = 1'b0;
          state_d    = RUN;
        end
        RUN: begin
          ip_d       = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + ADDR_ONE;
          no_op_d    = 1'b0;
          if (call_performed) begin
            // The word already being read is wrong-path: one bubble
            fetch_pc_d = ip_to_call;
            no_op_d    = 1'b1;
          end else if (!no_op_q && opcode == OP_RETURN) begin
            // Target comes later from data memory; park until it arrives
            state_d = RET_WAIT;
            no_op_d = 1'b1;
          end
        end
        RET_WAIT: begin
          no_op_d = 1'b1;
          if (return_performed) begin
            fetch_pc_d = return_addr[ADDR_SIZE-1:0];
            state_d    = FILL;
          end
        end
        HALT: begin
          no_op_d = 1'b1;
        end
        default: begin
          state_d = FILL;
          no_op_d = 1'b1;
        end
      endcase
    end
    read_en_d = (state_d == FILL) || (state_d == RUN);
  end

  // Fetch registers; reset restarts at the vector and drops any pending target
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= FILL;
      fetch_pc_q <= RESET_VECTOR;
      ip_q       <= RESET_VECTOR;
      no_op_q    <= 1'b1;
      read_en_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ip_q       <= ip_d;
      no_op_q    <= no_op_d;
      read_en_q  <= read_en_d;
    end
  end

  // Redirects are only meaningful in the states that can act on them
  a_call_in_run : assert property (@(posedge clock) disable iff (!reset)
    call_performed |-> (state_q == RUN));
  a_return_in_wait : assert property (@(posedge clock) disable iff (!reset)
    return_performed |-> (state_q == RET_WAIT));

endmodule

// File: tb/tb_processor_stage1.sv
// tb/tb_processor_stage1.sv - directed bench for the fetch stage
module tb_processor_stage1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [17:0] code_addr, code_data, ip, ip_plus_one, code_word;
  logic        code_read_enable, no_operation;
  logic        call_performed = 1'b0;
  logic [17:0] ip_to_call = '0;
  logic        return_performed = 1'b0;
  logic [17:0] return_addr = '0;
  logic        waiting_global = 1'b0;

  logic [17:0] code_addr6, code_data6, ip6, ip_plus_one6, code_word6;
  logic        code_read_enable6, no_operation6;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  processor_stage1 dut (
    .clock(clock), .reset(reset), .code_addr(code_addr), .code_read_enable(code_read_enable),
    .code_data(code_data), .no_operation(no_operation), .ip(ip), .ip_plus_one(ip_plus_one),
    .code_word(code_word), .call_performed(call_performed), .ip_to_call(ip_to_call),
    .return_performed(return_performed), .return_addr(return_addr),
    .waiting_global(waiting_global)
  );

  processor_stage1 #(.RESET_VECTOR(18'h3FFFE)) dut6 (
    .clock(clock), .reset(reset), .code_addr(code_addr6), .code_read_enable(code_read_enable6),
    .code_data(code_data6), .no_operation(no_operation6), .ip(ip6), .ip_plus_one(ip_plus_one6),
    .code_word(code_word6), .call_performed(1'b0), .ip_to_call(18'h0),
    .return_performed(1'b0), .return_addr(18'h0), .waiting_global(1'b0)
  );

  // Code image: word = address + 100, except a return instruction at address 7
  function automatic logic [17:0] mem_word(input logic [17:0] a);
    if (a == 18'd7) return 18'h38000;
    return a + 18'd100;
  endfunction

  always @(posedge clock) if (code_read_enable) code_data <= mem_word(code_addr);
  always @(posedge clock) if (code_read_enable6) code_data6 <= mem_word(code_addr6);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    call_performed = 1'b0;
    return_performed = 1'b0;
    waiting_global = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (no_operation !== 1'b1 || ip !== 18'd0 || code_addr !== 18'd0 || code_read_enable !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: nop=%b ip=%h addr=%h en=%b want nop=1 ip=0 addr=0 en=1",
               no_operation, ip, code_addr, code_read_enable);
    end
    total++;
    if (ip6 !== 18'h3FFFE || code_addr6 !== 18'h3FFFE || no_operation6 !== 1'b1) begin
      bad++;
      $display("FAIL reset_vector6: ip=%h addr=%h nop=%b want ip=3fffe addr=3fffe nop=1",
               ip6, code_addr6, no_operation6);
    end
    repeat (4) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    total++;
    if (no_operation !== 1'b1 || ip !== 18'd0 || code_addr !== 18'd0) begin
      bad++;
      $display("FAIL async_reset: nop=%b ip=%h addr=%h want nop=1 ip=0 addr=0",
               no_operation, ip, code_addr);
    end
  endtask

  task automatic test_sequential();
    logic [17:0] e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      e = 18'(i);
      total++;
      if (no_operation !== 1'b0 || ip !== e || code_word !== e + 18'd100 || ip_plus_one !== e + 18'd1) begin
        bad++;
        $display("FAIL seq_%0d: nop=%b ip=%h word=%h ipp1=%h want nop=0 ip=%h word=%h ipp1=%h",
                 i, no_operation, ip, code_word, ip_plus_one, e, e + 18'd100, e + 18'd1);
      end
    end
  endtask

  task automatic test_call();
    call_performed = 1'b1;
    ip_to_call = 18'h200;
    @(negedge clock);
    call_performed = 1'b0;
    total++;
    if (no_operation !== 1'b1) begin
      bad++;
      $display("FAIL call_bubble: nop=%b want 1", no_operation);
    end
    @(negedge clock);
    total++;
    if (no_operation !== 1'b0 || ip !== 18'h200 || code_word !== 18'h264 || ip_plus_one !== 18'h201) begin
      bad++;
      $display("FAIL call_target: nop=%b ip=%h word=%h ipp1=%h want nop=0 ip=200 word=264 ipp1=201",
               no_operation, ip, code_word, ip_plus_one);
    end
    @(negedge clock);
    total++;
    if (no_operation !== 1'b0 || ip !== 18'h201 || code_word !== 18'h265) begin
      bad++;
      $display("FAIL call_next: nop=%b ip=%h word=%h want nop=0 ip=201 word=265",
               no_operation, ip, code_word);
    end
  endtask

  task automatic run_to_return();
    do_reset();
    repeat (8) @(negedge clock);
    total++;
    if (no_operation !== 1'b0 || ip !== 18'd7 || code_word !== 18'h38000) begin
      bad++;
      $display("FAIL ret_word: nop=%b ip=%h word=%h want nop=0 ip=7 word=38000",
               no_operation, ip, code_word);
    end
  endtask

  task automatic test_return();
    run_to_return();
    @(negedge clock);
    total++;
    if (no_operation !== 1'b1 || code_read_enable !== 1'b0) begin
      bad++;
      $display("FAIL ret_bubble1: nop=%b en=%b want nop=1 en=0", no_operation, code_read_enable);
    end
    @(negedge clock);
    total++;
    if (no_operation !== 1'b1) begin
      bad++;
      $display("FAIL ret_bubble2: nop=%b want 1", no_operation);
    end
    return_performed = 1'b1;
    return_addr = 18'h30;
    @(negedge clock);
    return_performed = 1'b0;
    total++;
    if (no_operation !== 1'b1 || code_read_enable !== 1'b1 || code_addr !== 18'h30) begin
      bad++;
      $display("FAIL ret_bubble3: nop=%b en=%b addr=%h want nop=1 en=1 addr=30",
               no_operation, code_read_enable, code_addr);
    end
    @(negedge clock);
    total++;
    if (no_operation !== 1'b0 || ip !== 18'h30 || code_word !== 18'h94) begin
      bad++;
      $display("FAIL ret_target: nop=%b ip=%h word=%h want nop=0 ip=30 word=94",
               no_operation, ip, code_word);
    end
    @(negedge clock);
    total++;
    if (no_operation !== 1'b0 || ip !== 18'h31 || code_word !== 18'h95) begin
      bad++;
      $display("FAIL ret_next: nop=%b ip=%h word=%h want nop=0 ip=31 word=95",
               no_operation, ip, code_word);
    end
  endtask

  task automatic test_return_wait();
    run_to_return();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      total++;
      if (no_operation !== 1'b1 || code_read_enable !== 1'b0) begin
        bad++;
        $display("FAIL ret_wait_%0d: nop=%b en=%b want nop=1 en=0", i, no_operation, code_read_enable);
      end
    end
    return_performed = 1'b1;
    return_addr = 18'h40;
    @(negedge clock);
    return_performed = 1'b0;
    @(negedge clock);
    total++;
    if (no_operation !== 1'b0 || ip !== 18'h40 || code_word !== 18'hA4) begin
      bad++;
      $display("FAIL ret_wait_resume: nop=%b ip=%h word=%h want nop=0 ip=40 word=a4",
               no_operation, ip, code_word);
    end
    @(negedge clock);
    total++;
    if (ip !== 18'h41 || code_word !== 18'hA5) begin
      bad++;
      $display("FAIL ret_wait_next: ip=%h word=%h want ip=41 word=a5", ip, code_word);
    end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (4) @(negedge clock);
    waiting_global = 1'b1;
    call_performed = 1'b1;
    ip_to_call = 18'h100;
    @(negedge clock);
    waiting_global = 1'b0;
    call_performed = 1'b0;
    for (int i = 0; i < 50; i++) begin
      total++;
      if (no_operation !== 1'b1 || code_read_enable !== 1'b0 || code_addr !== 18'd4 ||
          ip !== 18'd3 || ip_plus_one !== 18'd4 || code_word !== 18'd104) begin
        bad++;
        $display("FAIL halt_%0d: nop=%b en=%b addr=%h ip=%h ipp1=%h word=%h want 1 0 4 3 4 68",
                 i, no_operation, code_read_enable, code_addr, ip, ip_plus_one, code_word);
      end
      @(negedge clock);
    end
    do_reset();
    @(negedge clock);
    total++;
    if (no_operation !== 1'b0 || ip !== 18'd0 || code_word !== 18'd100) begin
      bad++;
      $display("FAIL halt_restart: nop=%b ip=%h word=%h want nop=0 ip=0 word=64",
               no_operation, ip, code_word);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clock);
    total++;
    if (no_operation6 !== 1'b0 || ip6 !== 18'h3FFFE || code_word6 !== 18'h62 || ip_plus_one6 !== 18'h3FFFF) begin
      bad++;
      $display("FAIL wrap_0: nop=%b ip=%h word=%h ipp1=%h want nop=0 ip=3fffe word=62 ipp1=3ffff",
               no_operation6, ip6, code_word6, ip_plus_one6);
    end
    @(negedge clock);
    total++;
    if (ip6 !== 18'h3FFFF || code_word6 !== 18'h63 || ip_plus_one6 !== 18'h0) begin
      bad++;
      $display("FAIL wrap_1: ip=%h word=%h ipp1=%h want ip=3ffff word=63 ipp1=0",
               ip6, code_word6, ip_plus_one6);
    end
    @(negedge clock);
    total++;
    if (ip6 !== 18'h0 || code_word6 !== 18'd100 || ip_plus_one6 !== 18'h1 || no_operation6 !== 1'b0) begin
      bad++;
      $display("FAIL wrap_2: ip=%h word=%h ipp1=%h nop=%b want ip=0 word=64 ipp1=1 nop=0",
               ip6, code_word6, ip_plus_one6, no_operation6);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_call();
    test_return();
    test_return_wait();
    test_halt();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
